// File: rtl/uart_cmd_host_pkg.sv
// Shared opcodes, command encodings, FSM states and frame builders for the
// UART command host.
package uart_cmd_host_pkg;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam int FRAME_LEN_RF_WR   = 3;
  localparam int FRAME_LEN_RF_RD   = 2;
  localparam int FRAME_LEN_ALU_OP  = 4;
  localparam int FRAME_LEN_ALU_NOP = 2;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_BSY,
    ST_WAIT_IDLE,
    ST_RSP_LO,
    ST_RSP_HI,
    ST_DONE
  } state_e;

  function automatic logic [1:0] frame_last(input cmd_type_e t);
    logic [1:0] last;
    unique case (t)
      CMD_RF_WR:  last = 2'(FRAME_LEN_RF_WR - 1);
      CMD_RF_RD:  last = 2'(FRAME_LEN_RF_RD - 1);
      CMD_ALU_OP: last = 2'(FRAME_LEN_ALU_OP - 1);
      default:    last = 2'(FRAME_LEN_ALU_NOP - 1);
    endcase
    return last;
  endfunction

  // Byte idx of the frame for command t; address/function are zero-extended.
  function automatic logic [7:0] frame_byte(input cmd_type_e t, input logic [1:0] idx,
                                            input logic [3:0] addr, input logic [7:0] a,
                                            input logic [7:0] b, input logic [3:0] fun);
    logic [7:0] val;
    unique case (idx)
      2'd0: begin
        unique case (t)
          CMD_RF_WR:  val = OP_RF_WR;
          CMD_RF_RD:  val = OP_RF_RD;
          CMD_ALU_OP: val = OP_ALU_OP;
          default:    val = OP_ALU_NOP;
        endcase
      end
      2'd1: begin
        unique case (t)
          CMD_RF_WR, CMD_RF_RD: val = {4'h0, addr};
          CMD_ALU_OP:           val = a;
          default:              val = {4'h0, fun};
        endcase
      end
      2'd2:    val = (t == CMD_RF_WR) ? a : b;
      default: val = {4'h0, fun};
    endcase
    return val;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout_cnt.sv
// Response-wait watchdog: clear has priority, counts while enabled, flags the
// cycle on which the LIMIT-th waiting cycle completes.
module uart_cmd_timeout_cnt #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expire = en && !clr && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side UART command initiator: frames one command into TX bytes and
// collects the response. Define UART_CMD_HOST_TIMEOUT_EN for the wait watchdog.
module uart_cmd_host
  import uart_cmd_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_TYPE,
  input  logic [3:0]  CMD_ADDR,
  input  logic [7:0]  CMD_A,
  input  logic [7:0]  CMD_B,
  input  logic [3:0]  CMD_FUN,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_VLD,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_P_DATA,
  input  logic        RX_D_VLD,
  output logic [15:0] RSP_DATA,
  output logic        RSP_VALID,
  output logic        RSP_TIMEOUT
);

  state_e     state;
  cmd_type_e  typ_q;
  logic [3:0] addr_q, fun_q;
  logic [7:0] a_q, b_q;
  logic [1:0] idx;
  logic       expire;

`ifdef UART_CMD_HOST_TIMEOUT_EN
  logic counting, rsp_state, cnt_clr;

  // Leaving the counted states clears the counter, so entry always starts at 0.
  assign counting  = (state == ST_WAIT_BSY) || (state == ST_RSP_LO) || (state == ST_RSP_HI);
  assign rsp_state = (state == ST_RSP_LO) || (state == ST_RSP_HI);
  assign cnt_clr   = !counting || (rsp_state && RX_D_VLD) || (state == ST_WAIT_BSY && TX_BUSY);

  uart_cmd_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk    (CLK),
    .rst    (RST),
    .clr    (cnt_clr),
    .en     (counting),
    .expire (expire)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
  assign expire = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_IDLE;
      typ_q       <= CMD_RF_WR;
      addr_q      <= '0;
      fun_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      CMD_READY   <= 1'b1;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      RSP_DATA    <= '0;
      RSP_VALID   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      RSP_VALID   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      if (expire) begin
        RSP_VALID   <= 1'b1;
        RSP_TIMEOUT <= 1'b1;
        RSP_DATA    <= '0;
        state       <= ST_DONE;
      end else begin
        unique case (state)
          ST_IDLE: if (CMD_VALID) begin
            typ_q     <= cmd_type_e'(CMD_TYPE);
            addr_q    <= CMD_ADDR;
            fun_q     <= CMD_FUN;
            a_q       <= CMD_A;
            b_q       <= CMD_B;
            idx       <= '0;
            TX_P_DATA <= frame_byte(cmd_type_e'(CMD_TYPE), 2'd0, CMD_ADDR, CMD_A, CMD_B, CMD_FUN);
            TX_D_VLD  <= 1'b1;
            CMD_READY <= 1'b0;
            RSP_DATA  <= '0;
            state     <= ST_SEND;
          end
          ST_SEND: if (!TX_BUSY) begin
            TX_D_VLD <= 1'b0;
            state    <= ST_WAIT_BSY;
          end
          ST_WAIT_BSY: if (TX_BUSY) state <= ST_WAIT_IDLE;
          ST_WAIT_IDLE: if (!TX_BUSY) begin
            if (idx != frame_last(typ_q)) begin
              idx       <= idx + 2'd1;
              TX_P_DATA <= frame_byte(typ_q, idx + 2'd1, addr_q, a_q, b_q, fun_q);
              TX_D_VLD  <= 1'b1;
              state     <= ST_SEND;
            end else if (typ_q == CMD_RF_WR) begin
              RSP_VALID <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_RSP_LO;
            end
          end
          ST_RSP_LO: if (RX_D_VLD) begin
            RSP_DATA[7:0] <= RX_P_DATA;
            if (typ_q == CMD_RF_RD) begin
              RSP_VALID <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_RSP_HI;
            end
          end
          ST_RSP_HI: if (RX_D_VLD) begin
            RSP_DATA[15:8] <= RX_P_DATA;
            RSP_VALID      <= 1'b1;
            state          <= ST_DONE;
          end
          ST_DONE: begin
            CMD_READY <= 1'b1;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
